// File: rtl/fm7_io_strobe_gen.sv
// Bus-cycle sequencer feeding the 3-to-8 I/O select decoder: latches an I/O request
// in the $FDxx window and walks the decoder enables through setup, strobe and hold phases.
module fm7_io_strobe_gen #(
   parameter logic [7:0] BASE_HI    = 8'hFD,
   parameter logic [1:0] WIN_HI     = 2'b00,
   parameter int         SETUP_CYC  = 1,
   parameter int         STROBE_CYC = 2,
   parameter int         HOLD_CYC   = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic        rw,
   output logic        busy,
   output logic        ack,
   output logic        miss,
   output logic        g1,
   output logic        g2a_n,
   output logic        g2b_n,
   output logic [2:0]  sel,
   output logic        rd_n,
   output logic        wr_n,
   output logic [2:0]  dbg_state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_STROBE = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int         STROBE_EFF  = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
   localparam logic [3:0] SETUP_LAST  = 4'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
   localparam logic [3:0] STROBE_LAST = 4'(STROBE_EFF - 1);
   localparam logic [3:0] HOLD_LAST   = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

   logic [2:0] r_state;
   logic [2:0] w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_rw;
   logic       r_miss_l;
   logic       w_hit;
   logic       w_accept;
   logic       w_rw_nxt;
   logic       w_miss_nxt;
   logic       w_strobe_nxt;

   assign w_hit    = (addr[15:8] == BASE_HI) && (addr[7:6] == WIN_HI);
   assign w_accept = (r_state == S_IDLE) && req;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               if (!w_hit)              w_state_nxt = S_DONE;
               else if (SETUP_CYC == 0) w_state_nxt = S_STROBE;
               else                     w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            if (r_cnt == SETUP_LAST) w_state_nxt = S_STROBE;
         end
         S_STROBE: begin
            if (r_cnt == STROBE_LAST) w_state_nxt = (HOLD_CYC == 0) ? S_DONE : S_HOLD;
         end
         S_HOLD: begin
            if (r_cnt == HOLD_LAST) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Counter restarts on every state entry and only runs in the timed phases.
   assign w_cnt_nxt = ((w_state_nxt != r_state) || (r_state == S_IDLE)) ? 4'd0 : r_cnt + 4'd1;

   // Direction and miss flag come straight from the inputs on the acceptance edge so that
   // a zero-length setup can still drive the correct qualifier on its first strobe cycle.
   assign w_rw_nxt     = w_accept ? rw : r_rw;
   assign w_miss_nxt   = w_accept ? !w_hit : r_miss_l;
   assign w_strobe_nxt = (w_state_nxt == S_STROBE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_rw     <= 1'b0;
         r_miss_l <= 1'b0;
         busy     <= 1'b0;
         ack      <= 1'b0;
         miss     <= 1'b0;
         g1       <= 1'b0;
         g2a_n    <= 1'b1;
         g2b_n    <= 1'b1;
         sel      <= 3'b000;
         rd_n     <= 1'b1;
         wr_n     <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rw     <= w_rw_nxt;
         r_miss_l <= w_miss_nxt;
         if (w_accept && w_hit) sel <= addr[5:3];
         busy     <= (w_state_nxt != S_IDLE);
         ack      <= (w_state_nxt == S_DONE);
         miss     <= (w_state_nxt == S_DONE) && w_miss_nxt;
         // Enables and qualifiers all derive from the same next-state term: one edge, no partial combos.
         g1       <= w_strobe_nxt;
         g2a_n    <= !w_strobe_nxt;
         g2b_n    <= !w_strobe_nxt;
         rd_n     <= !(w_strobe_nxt && w_rw_nxt);
         wr_n     <= !(w_strobe_nxt && !w_rw_nxt);
      end
   end

   assign dbg_state = r_state;

endmodule

// File: tb/tb_fm7_io_strobe_gen.sv
// Bench for fm7_io_strobe_gen: default-parameter and zero-length-phase instances checked
// against a per-cycle output trace built from the transaction rules.
`timescale 1ns/1ps
module tb_fm7_io_strobe_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_d = 1'b0, rw_d = 1'b0;
  logic [15:0] addr_d = 16'h0000;
  logic        req_z = 1'b0, rw_z = 1'b0;
  logic [15:0] addr_z = 16'h0000;

  logic busy_d, ack_d, miss_d, g1_d, g2a_n_d, g2b_n_d, rd_n_d, wr_n_d;
  logic [2:0] sel_d, dbg_d;
  logic busy_z, ack_z, miss_z, g1_z, g2a_n_z, g2b_n_z, rd_n_z, wr_n_z;
  logic [2:0] sel_z, dbg_z;

  fm7_io_strobe_gen u_dut_d (
    .clk(clk), .reset_n(reset_n), .req(req_d), .addr(addr_d), .rw(rw_d),
    .busy(busy_d), .ack(ack_d), .miss(miss_d), .g1(g1_d), .g2a_n(g2a_n_d), .g2b_n(g2b_n_d),
    .sel(sel_d), .rd_n(rd_n_d), .wr_n(wr_n_d), .dbg_state(dbg_d)
  );

  fm7_io_strobe_gen #(.SETUP_CYC(0), .STROBE_CYC(0), .HOLD_CYC(0)) u_dut_z (
    .clk(clk), .reset_n(reset_n), .req(req_z), .addr(addr_z), .rw(rw_z),
    .busy(busy_z), .ack(ack_z), .miss(miss_z), .g1(g1_z), .g2a_n(g2a_n_z), .g2b_n(g2b_n_z),
    .sel(sel_z), .rd_n(rd_n_z), .wr_n(wr_n_z), .dbg_state(dbg_z)
  );

  // packed view: {busy, ack, miss, g1, g2a_n, g2b_n, sel[2:0], rd_n, wr_n}
  logic [10:0] obs_d, obs_z;
  assign obs_d = {busy_d, ack_d, miss_d, g1_d, g2a_n_d, g2b_n_d, sel_d, rd_n_d, wr_n_d};
  assign obs_z = {busy_z, ack_z, miss_z, g1_z, g2a_n_z, g2b_n_z, sel_z, rd_n_z, wr_n_z};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];
  logic [2:0] last_sel_d = 3'b000;
  logic [2:0] last_sel_z = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [10:0] pack(input logic b, input logic a, input logic m, input logic g,
                                       input logic [2:0] s, input logic rdn, input logic wrn);
    return {b, a, m, g, ~g, ~g, s, rdn, wrn};
  endfunction

  function automatic bit is_hit(input logic [15:0] a);
    return (a[15:8] == 8'hFD) && (a[7:6] == 2'b00);
  endfunction

  // Expected outputs for every cycle after acceptance, ending with the first IDLE cycle.
  function automatic void build_trace(input logic [15:0] a, input logic r, input int s, input int t,
                                      input int h, input logic [2:0] prev_sel);
    logic [2:0] ns;
    int ts;
    ns = a[5:3];
    ts = (t < 1) ? 1 : t;
    if (!is_hit(a)) begin
      exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b0, prev_sel, 1'b1, 1'b1));
      exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, prev_sel, 1'b1, 1'b1));
      return;
    end
    for (int k = 0; k < s; k++)  exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, ns, 1'b1, 1'b1));
    for (int k = 0; k < ts; k++) exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b1, ns, ~r, r));
    for (int k = 0; k < h; k++)  exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, ns, 1'b1, 1'b1));
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, ns, 1'b1, 1'b1));
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, ns, 1'b1, 1'b1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit z, input logic q, input logic [15:0] a, input logic r);
    if (z) begin req_z = q; addr_z = a; rw_z = r; end
    else   begin req_d = q; addr_d = a; rw_d = r; end
  endtask

  // Called at a negedge with the selected DUT idle. Holds req through the ack cycle and
  // drops it in the first IDLE cycle; returns at that IDLE cycle's negedge.
  task automatic run_txn(input bit z, input logic [15:0] a, input logic r, input bit scramble,
                         output int ack_cyc, output int strb_cnt, output logic [2:0] strb_sel);
    logic [10:0] exp, act;
    int n;
    exp_q.delete();
    if (z) build_trace(a, r, 0, 0, 0, last_sel_z);
    else   build_trace(a, r, 1, 2, 1, last_sel_d);
    if (is_hit(a)) begin
      if (z) last_sel_z = a[5:3];
      else   last_sel_d = a[5:3];
    end
    ack_cyc = -1;
    strb_cnt = 0;
    strb_sel = 3'b000;
    n = 0;
    drive(z, 1'b1, a, r);
    @(posedge clk);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 1)  drive(z, 1'b0, a, r);
      else if (scramble)      drive(z, 1'b1, 16'($urandom), 1'($urandom));
      exp = exp_q.pop_front();
      act = z ? obs_z : obs_d;
      check($sformatf("trace%s c%0d", z ? "_z" : "_d", n), 32'(act), 32'(exp));
      if (act[9] === 1'b1 && ack_cyc < 0) ack_cyc = n;
      if (act[7] === 1'b1) begin
        strb_cnt++;
        strb_sel = act[4:2];
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_d", 32'(obs_d), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, last_sel_d, 1'b1, 1'b1)));
      check("idle_z", 32'(obs_z), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, last_sel_z, 1'b1, 1'b1)));
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          z;
    logic [15:0] addr;
    logic        rw;
    int          exp_lat;
    int          exp_strb;
    logic [2:0]  exp_sel;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, scnt;
    logic [2:0] ssel;

    vecs[0] = '{1'b0, 16'hFD18, 1'b1, 5, 2, 3'b011};
    vecs[1] = '{1'b0, 16'hFD38, 1'b0, 5, 2, 3'b111};
    vecs[2] = '{1'b0, 16'hFD40, 1'b1, 1, 0, 3'b000};
    vecs[3] = '{1'b0, 16'hFC18, 1'b0, 1, 0, 3'b000};
    vecs[4] = '{1'b0, 16'hFDC0, 1'b1, 1, 0, 3'b000};
    vecs[5] = '{1'b0, 16'hFD3F, 1'b1, 5, 2, 3'b111};
    vecs[6] = '{1'b1, 16'hFD10, 1'b1, 2, 1, 3'b010};
    vecs[7] = '{1'b1, 16'hFD28, 1'b0, 2, 1, 3'b101};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_d", 32'(obs_d), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1)));
    check("reset_z", 32'(obs_z), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1)));
    reset_n = 1'b1;
    idle_cycles(10);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].z, vecs[i].addr, vecs[i].rw, 1'b0, lat, scnt, ssel);
      check($sformatf("v%0d_ack_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_strobes", i), 32'(scnt), 32'(vecs[i].exp_strb));
      if (vecs[i].exp_strb > 0) check($sformatf("v%0d_sel", i), 32'(ssel), 32'(vecs[i].exp_sel));
    end
    idle_cycles(2);

    // reset pulsed during the second strobe cycle of a read
    drive(1'b0, 1'b1, 16'hFD08, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'hFD08, 1'b1);
    check("rst_setup_g1", 32'(g1_d), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    check("rst_pre_strobe", 32'({g1_d, g2a_n_d, g2b_n_d, rd_n_d, wr_n_d}), 32'(5'b10001));
    reset_n = 1'b0;
    #1;
    check("rst_async_enables", 32'({g1_d, g2a_n_d, g2b_n_d, rd_n_d, wr_n_d, ack_d}), 32'(6'b011110));
    last_sel_d = 3'b000;
    last_sel_z = 3'b000;
    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(3);
    run_txn(1'b0, 16'hFD00, 1'b1, 1'b0, lat, scnt, ssel);
    check("post_rst_lat", 32'(lat), 32'd5);
    check("post_rst_sel", 32'(ssel), 32'd0);

    // randomized transactions on both instances
    for (int i = 0; i < 60; i++) begin
      bit z;
      logic [15:0] a;
      z = i[0];
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[15:8] = 8'hFD;
      if ($urandom_range(0, 2) != 0) a[7:6] = 2'b00;
      run_txn(z, a, 1'($urandom_range(0, 1)), 1'b1, lat, scnt, ssel);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm7_io_strobe_gen.md
Name: fm7_io_strobe_gen

Overview:
- Bus-cycle sequencer directly upstream of the 3-to-8 I/O select decoder, which has inputs G1, G2A, G2B, A, B and C.
- Latches a CPU I/O request in the $FDxx window.
- Drives registered, glitch-free decoder enables and select code through setup, strobe and hold phases.
- Returns a one-cycle ack so the CPU wrapper can release its stall.

Parameters:
- BASE_HI, 8'hFD: address bits [15:8] that identify the I/O page.
- WIN_HI, 2'b00: address bits [7:6] that identify the decoded 64-byte window.
- SETUP_CYC, 1: cycles the select code is stable before enables assert. 0 skips the SETUP state.
- STROBE_CYC, 2: cycles the enables are active. 0 is treated as 1.
- HOLD_CYC, 1: cycles the select code is held after enables deassert. 0 skips the HOLD state.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  request strobe, sampled only in IDLE.
- addr  in  16  CPU address, sampled with req.
- rw  in  1  1 = read, 0 = write, sampled with req.
- busy  out  1  high from the cycle after acceptance through the ack cycle.
- ack  out  1  one-cycle pulse at completion of every accepted request.
- miss  out  1  valid with ack; 1 = address outside the window, no strobe issued.
- g1  out  1  decoder G1 (active high).
- g2a_n  out  1  decoder G2A (active low).
- g2b_n  out  1  decoder G2B (active low).
- sel  out  3  decoder {C,B,A} = addr[5:3] of the latched request.
- rd_n  out  1  active-low read qualifier, low only during STROBE of a read.
- wr_n  out  1  active-low write qualifier, low only during STROBE of a write.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, ack=0, miss=0, g1=0, g2a_n=1, g2b_n=1, sel=3'b000, rd_n=1, wr_n=1; FSM in IDLE; cycle counter = 0.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE, req=1 and addr matches (addr[15:8]==BASE_HI and addr[7:6]==WIN_HI):
  - latch sel<=addr[5:3] and rw; busy<=1.
  - Go to SETUP, or to STROBE if SETUP_CYC==0.
- IDLE, req=1 and no match:
  - busy<=1, go to DONE with miss flag set.
  - Decoder enables never assert.
- SETUP:
  - sel stable, g1=0, g2a_n=g2b_n=1.
  - Stay SETUP_CYC cycles, then go to STROBE.
- STROBE:
  - g1=1, g2a_n=0, g2b_n=0; rd_n=~rw_l; wr_n=rw_l.
  - Stay max(STROBE_CYC,1) cycles.
  - Then go to HOLD, or to DONE if HOLD_CYC==0.
- HOLD:
  - Enables and qualifiers inactive, sel unchanged.
  - Stay HOLD_CYC cycles, then go to DONE.
- DONE:
  - ack=1 for exactly one cycle; miss=1 if the request missed the window, else 0; busy=1.
  - Next state is IDLE, where busy=0, ack=0 and miss=0.
- Enables (g1, g2a_n, g2b_n) and rd_n/wr_n change together on the same clock edge. No cycle may show a partial enable combination.
- sel never changes while g1=1. sel keeps its last value in IDLE.
- req outside IDLE is ignored. No queueing. The CPU wrapper must hold req until ack.
- req held high through DONE does not start a new transaction in DONE. The earliest next acceptance is the first IDLE cycle.
- Latency, match case: acceptance edge to ack = SETUP_CYC + max(STROBE_CYC,1) + HOLD_CYC + 1 cycles. Defaults: ack is the 5th cycle after the acceptance edge.
- Latency, miss case: ack on the cycle after acceptance.
- Cycle counter is 4 bits wide. Parameters above 15 are not supported. Counter resets to 0 on every state entry.
- reset_n low at any time, including mid-STROBE:
  - enables drop immediately (asynchronously) to their inactive values; no ack is issued.
  - On release, the FSM is in IDLE.

Test Plan:
- Reset, then idle 10 cycles -> g1=0, g2a_n=g2b_n=1, rd_n=wr_n=1, busy=0, ack=0 throughout.
- Read req, addr=16'hFD18, rw=1, default parameters -> sel=3'b011 from the cycle after acceptance. g1=1, g2a_n=g2b_n=0, rd_n=0 for exactly 2 cycles starting 2 cycles after acceptance. ack=1 with miss=0 on cycle 5. wr_n stays 1.
- Write req, addr=16'hFD38, rw=0 -> sel=3'b111, wr_n=0 during STROBE only, rd_n=1 throughout.
- Miss req, addr=16'hFD40, then a second miss at addr=16'hFC18 -> each gives ack=1 and miss=1 on the cycle after acceptance. g1 never asserts.
- reset_n pulsed low during the 2nd STROBE cycle of a read to 16'hFD08 -> g1=0, g2a_n=g2b_n=1, rd_n=1 during reset. No ack. After release, a new request at 16'hFD00 completes normally with sel=3'b000.
- SETUP_CYC=0, STROBE_CYC=0, HOLD_CYC=0, back-to-back reqs at 16'hFD10 and 16'hFD28 -> 1-cycle strobe with sel=3'b010, then sel=3'b101. ack on the 2nd cycle after each acceptance. The second request is accepted only in the IDLE cycle after the first ack.
